mips: RTL and testbench

- 32-bit 5-stage pipelined MIPS subset core: IF, ID, EX, MEM, WB.
- Has internal instruction ROM, data RAM and 32x32 register file.
- Provides EX-stage forwarding, load-use stall and branch flush.
- Top of the CPU hierarchy; the only ports are clock and reset. Debug visibility is through fixed internal signal names.

---
 rtl/mips.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mips.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips.sv
module mips #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "instructions.mem"
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        alusrc;
    alu_op_e     aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } idex_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] store;
  } exmem_t;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] load;
  } memwb_t;

  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WB_WriteData;
  logic [31:0] Bus_A_ALU;
  logic [31:0] Bus_B_ALU;

  logic [31:0] pc_q = '0;
  logic [31:0] pc_d;
  ifid_t       ifid_q = '0;
  ifid_t       ifid_d;
  idex_t       idex_q = '0;
  idex_t       idex_d;
  exmem_t      exmem_q = '0;
  exmem_t      exmem_d;
  memwb_t      memwb_q = '0;
  memwb_t      memwb_d;

  logic [31:0] imem [IMEM_DEPTH] = '{default: '0};
  logic [31:0] rf_q [32] = '{default: '0};
  logic [31:0] dmem_q [DMEM_DEPTH] = '{default: '0};

  assign PC          = pc_q;
  assign Instruction = imem[PC[IAW+1:2]];

  logic [5:0]  id_op;
  logic [5:0]  id_fn;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  idex_t       id_dec;

  assign id_op  = ifid_q.instr[31:26];
  assign id_rs  = ifid_q.instr[25:21];
  assign id_rt  = ifid_q.instr[20:16];
  assign id_rd  = ifid_q.instr[15:11];
  assign id_fn  = ifid_q.instr[5:0];
  assign id_imm = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};

  always_comb begin
    ReadData1 = rf_q[id_rs];
    ReadData2 = rf_q[id_rt];
    if (id_rs == 5'd0) begin
      ReadData1 = '0;
    end else if (memwb_q.regwrite && (memwb_q.dest == id_rs)) begin
      ReadData1 = WB_WriteData;
    end
    if (id_rt == 5'd0) begin
      ReadData2 = '0;
    end else if (memwb_q.regwrite && (memwb_q.dest == id_rt)) begin
      ReadData2 = WB_WriteData;
    end
  end

  always_comb begin
    id_dec     = '0;
    id_dec.rs  = id_rs;
    id_dec.rt  = id_rt;
    id_dec.rd1 = ReadData1;
    id_dec.rd2 = ReadData2;
    id_dec.imm = id_imm;
    id_dec.pc4 = ifid_q.pc4;
    unique case (id_op)
      OP_RTYPE: begin
        id_dec.dest = id_rd;
        unique case (id_fn)
          FN_ADD: begin id_dec.regwrite = 1'b1; id_dec.aluop = ALU_ADD; end
          FN_SUB: begin id_dec.regwrite = 1'b1; id_dec.aluop = ALU_SUB; end
          FN_AND: begin id_dec.regwrite = 1'b1; id_dec.aluop = ALU_AND; end
          FN_OR:  begin id_dec.regwrite = 1'b1; id_dec.aluop = ALU_OR;  end
          FN_SLT: begin id_dec.regwrite = 1'b1; id_dec.aluop = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        id_dec.regwrite = 1'b1;
        id_dec.memread  = 1'b1;
        id_dec.alusrc   = 1'b1;
        id_dec.dest     = id_rt;
      end
      OP_SW: begin
        id_dec.memwrite = 1'b1;
        id_dec.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        id_dec.branch = 1'b1;
      end
      OP_ADDI: begin
        id_dec.regwrite = 1'b1;
        id_dec.alusrc   = 1'b1;
        id_dec.dest     = id_rt;
      end
      default: ;
    endcase
  end

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_res;
  logic        br_taken;
  logic [31:0] br_target;

  always_comb begin
    fwd_a = idex_q.rd1;
    fwd_b = idex_q.rd2;
    if (exmem_q.regwrite && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rs)) begin
      fwd_a = exmem_q.alu;
    end else if (memwb_q.regwrite && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rs)) begin
      fwd_a = WB_WriteData;
    end
    if (exmem_q.regwrite && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rt)) begin
      fwd_b = exmem_q.alu;
    end else if (memwb_q.regwrite && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rt)) begin
      fwd_b = WB_WriteData;
    end
    Bus_A_ALU = fwd_a;
    Bus_B_ALU = idex_q.alusrc ? idex_q.imm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    unique case (idex_q.aluop)
      ALU_ADD: alu_res = Bus_A_ALU + Bus_B_ALU;
      ALU_SUB: alu_res = Bus_A_ALU - Bus_B_ALU;
      ALU_AND: alu_res = Bus_A_ALU & Bus_B_ALU;
      ALU_OR:  alu_res = Bus_A_ALU | Bus_B_ALU;
      ALU_SLT: alu_res = {31'd0, ($signed(Bus_A_ALU) < $signed(Bus_B_ALU))};
      default: alu_res = '0;
    endcase
    br_taken  = idex_q.branch && (fwd_a == fwd_b);
    br_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};
  end

  logic [DAW-1:0] dmem_addr;
  assign dmem_addr    = exmem_q.alu[DAW+1:2];
  assign WB_WriteData = memwb_q.memtoreg ? memwb_q.load : memwb_q.alu;

  logic stall;
  always_comb begin
    stall = idex_q.memread && (idex_q.dest != 5'd0) &&
            ((idex_q.dest == id_rs) || (idex_q.dest == id_rt));

    pc_d         = pc_q + 32'd4;
    ifid_d.pc4   = pc_q + 32'd4;
    ifid_d.instr = Instruction;
    idex_d       = id_dec;
    if (br_taken) begin
      pc_d   = br_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end

    exmem_d.regwrite = idex_q.regwrite;
    exmem_d.memread  = idex_q.memread;
    exmem_d.memwrite = idex_q.memwrite;
    exmem_d.dest     = idex_q.dest;
    exmem_d.alu      = alu_res;
    exmem_d.store    = fwd_b;

    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memread;
    memwb_d.dest     = exmem_q.dest;
    memwb_d.alu      = exmem_q.alu;
    memwb_d.load     = dmem_q[dmem_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i[4:0]] <= '0;
    end else if (memwb_q.regwrite && (memwb_q.dest != 5'd0)) begin
      rf_q[memwb_q.dest] <= WB_WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem_q[i[DAW-1:0]] <= '0;
    end else if (exmem_q.memwrite) begin
      dmem_q[dmem_addr] <= exmem_q.store;
    end
  end

endmodule

// File: tb/tb_mips.sv
// tb_mips: directed pipeline-timing checks plus random programs compared against
// an instruction-level (non-pipelined) interpreter of the same instruction set.
module tb_mips;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mips #(
        .IMEM_DEPTH(256),
        .DMEM_DEPTH(256),
        .IMEM_FILE ("")
    ) dut (
        .clk  (clk),
        .reset(reset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [$];
    logic [31:0] mreg [32];
    logic [31:0] mmem [256];

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Load prog into ROM, then apply one reset edge; returns just after that edge
    task automatic load_and_reset();
        for (int i = 0; i < 256; i++) dut.imem[i[7:0]] = '0;
        for (int i = 0; i < prog.size(); i++) dut.imem[i[7:0]] = prog[i];
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sequential architectural interpreter: one instruction at a time, no pipeline
    task automatic model_run();
        int          pc;
        int          steps;
        logic [31:0] ins, a, b, simm, ea;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  op, fn;
        logic [7:0]  widx;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        for (int i = 0; i < 256; i++) mmem[i] = '0;
        pc    = 0;
        steps = 0;
        while (pc >= 0 && pc < prog.size() && steps < 1000) begin
            ins  = prog[pc];
            op   = ins[31:26];
            rs   = ins[25:21];
            rt   = ins[20:16];
            rd   = ins[15:11];
            fn   = ins[5:0];
            a    = mreg[rs];
            b    = mreg[rt];
            simm = {{16{ins[15]}}, ins[15:0]};
            ea   = a + simm;
            widx = 8'((ea / 4) % 256);
            steps++;
            pc++;
            case (op)
                6'h00: case (fn)
                    6'h20: mreg[rd] = a + b;
                    6'h22: mreg[rd] = a - b;
                    6'h24: mreg[rd] = a & b;
                    6'h25: mreg[rd] = a | b;
                    6'h2A: mreg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ;
                endcase
                6'h23: mreg[rt] = mmem[widx];
                6'h2B: mmem[widx] = b;
                6'h04: if (a == b) pc = pc + int'($signed(simm));
                6'h08: mreg[rt] = a + simm;
                default: ;
            endcase
            mreg[0] = '0;
        end
    endtask

    task automatic gen_prog();
        logic [4:0] x, y, z;
        prog.delete();
        for (int k = 0; k < 32; k++) begin
            x = 5'($urandom_range(0, 7));
            y = 5'($urandom_range(0, 7));
            z = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 11))
                0, 1: prog.push_back(i_ins(6'h08, x, y, 16'($urandom)));
                2:    prog.push_back(r_ins(6'h20, x, y, z));
                3:    prog.push_back(r_ins(6'h22, x, y, z));
                4:    prog.push_back(r_ins(6'h24, x, y, z));
                5:    prog.push_back(r_ins(6'h25, x, y, z));
                6:    prog.push_back(r_ins(6'h2A, x, y, z));
                7:    prog.push_back(i_ins(6'h23, x, y, 16'($urandom_range(0, 1023))));
                8:    prog.push_back(i_ins(6'h2B, x, y, 16'($urandom_range(0, 1023))));
                9:    prog.push_back(i_ins(6'h04, x, y, 16'($urandom_range(0, 3))));
                10:   prog.push_back(i_ins(6'h0D, x, y, 16'($urandom)));
                default: prog.push_back(r_ins(6'h26, x, y, z));
            endcase
        end
    endtask

    initial begin
        // ---- reset state ----
        prog.delete();
        load_and_reset();
        chk("reset_pc", dut.PC, 32'd0);
        chk("reset_wbdata", dut.WB_WriteData, 32'd0);

        // ---- back-to-back forwarding ----
        prog = '{i_ins(6'h08, 5'd1, 5'd0, 16'd5), i_ins(6'h08, 5'd2, 5'd0, 16'd7),
                 r_ins(6'h20, 5'd3, 5'd1, 5'd2)};
        load_and_reset();
        cyc(4);
        chk("fwd_busA", dut.Bus_A_ALU, 32'd5);
        chk("fwd_busB", dut.Bus_B_ALU, 32'd7);
        cyc(2);
        chk("fwd_wbdata", dut.WB_WriteData, 32'd12);
        cyc(1);
        chk("fwd_r3", dut.rf_q[3], 32'd12);

        // ---- store, load-use stall ----
        prog = '{i_ins(6'h08, 5'd1, 5'd0, 16'hFFFD), i_ins(6'h2B, 5'd1, 5'd0, 16'd8),
                 i_ins(6'h23, 5'd4, 5'd0, 16'd8), r_ins(6'h20, 5'd5, 5'd4, 5'd4)};
        load_and_reset();
        cyc(4);
        chk("lu_pc_e4", dut.PC, 32'd16);
        cyc(1);
        chk("lu_pc_held", dut.PC, 32'd16);
        cyc(1);
        chk("lu_pc_e6", dut.PC, 32'd20);
        cyc(1);
        chk("lu_pc_e7", dut.PC, 32'd24);
        cyc(6);
        chk("lu_mem2", dut.dmem_q[2], 32'hFFFFFFFD);
        chk("lu_r4", dut.rf_q[4], 32'hFFFFFFFD);
        chk("lu_r5", dut.rf_q[5], 32'hFFFFFFFA);

        // ---- taken branch flushes two instructions ----
        prog = '{i_ins(6'h08, 5'd1, 5'd0, 16'd1), i_ins(6'h04, 5'd1, 5'd1, 16'd2),
                 i_ins(6'h08, 5'd6, 5'd0, 16'd9), i_ins(6'h08, 5'd7, 5'd0, 16'd9),
                 i_ins(6'h08, 5'd8, 5'd0, 16'd4)};
        load_and_reset();
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk($sformatf("br_pc_e%0d", k), dut.PC, 32'(4 * k));
        end
        cyc(6);
        chk("br_r6", dut.rf_q[6], 32'd0);
        chk("br_r7", dut.rf_q[7], 32'd0);
        chk("br_r8", dut.rf_q[8], 32'd4);

        // ---- branch redirects PC away from sequential path ----
        prog = '{i_ins(6'h04, 5'd0, 5'd0, 16'd5)};
        load_and_reset();
        cyc(2);
        chk("br2_pc_e2", dut.PC, 32'd8);
        cyc(1);
        chk("br2_pc_target", dut.PC, 32'd24);
        cyc(1);
        chk("br2_pc_next", dut.PC, 32'd28);

        // ---- slt / sub / and / or ----
        prog = '{i_ins(6'h08, 5'd1, 5'd0, 16'd5), i_ins(6'h08, 5'd2, 5'd0, 16'hFFFE),
                 r_ins(6'h2A, 5'd3, 5'd1, 5'd2), r_ins(6'h2A, 5'd9, 5'd2, 5'd1),
                 r_ins(6'h22, 5'd4, 5'd2, 5'd1), r_ins(6'h24, 5'd5, 5'd1, 5'd2),
                 r_ins(6'h25, 5'd6, 5'd1, 5'd2)};
        load_and_reset();
        cyc(14);
        chk("slt_pos_neg", dut.rf_q[3], 32'd0);
        chk("slt_neg_pos", dut.rf_q[9], 32'd1);
        chk("sub", dut.rf_q[4], 32'hFFFFFFF9);
        chk("and", dut.rf_q[5], 32'd4);
        chk("or", dut.rf_q[6], 32'hFFFFFFFF);

        // ---- writes to $0 are not forwarded ----
        prog = '{i_ins(6'h08, 5'd0, 5'd0, 16'd9), r_ins(6'h20, 5'd1, 5'd0, 5'd0)};
        load_and_reset();
        cyc(3);
        chk("r0_busA", dut.Bus_A_ALU, 32'd0);
        chk("r0_busB", dut.Bus_B_ALU, 32'd0);
        cyc(5);
        chk("r0_r1", dut.rf_q[1], 32'd0);
        chk("r0_r0", dut.rf_q[0], 32'd0);

        // ---- reset mid-run and replay ----
        prog = '{i_ins(6'h08, 5'd1, 5'd0, 16'd5), i_ins(6'h08, 5'd2, 5'd0, 16'd7),
                 r_ins(6'h20, 5'd3, 5'd1, 5'd2)};
        load_and_reset();
        cyc(5);
        chk("mr_r1_before", dut.rf_q[1], 32'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_pc", dut.PC, 32'd0);
        chk("mr_instr", dut.Instruction, prog[0]);
        chk("mr_r1_cleared", dut.rf_q[1], 32'd0);
        cyc(7);
        chk("mr_r1", dut.rf_q[1], 32'd5);
        chk("mr_r2", dut.rf_q[2], 32'd7);
        chk("mr_r3", dut.rf_q[3], 32'd12);

        // ---- random programs vs interpreter ----
        for (int it = 0; it < 8; it++) begin
            gen_prog();
            model_run();
            load_and_reset();
            cyc(110);
            for (int i = 0; i < 32; i++)
                chk($sformatf("rnd%0d_reg%0d", it, i), dut.rf_q[i[4:0]], mreg[i]);
            for (int i = 0; i < 256; i++)
                chk($sformatf("rnd%0d_mem%0d", it, i), dut.dmem_q[i[7:0]], mmem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
